cpu_core: RTL and testbench
===========================

Name: cpu_core

Overview:
- Parametrised multi-cycle accumulator CPU; next generation of the 16-bit CPU top.
- Integrates instruction memory, data memory, IR, PC, A/B/C registers and ALU behind one FSM.
- Adds capabilities the previous top lacks:
  - generic data/address width
  - synchronous reset
  - program-load lockout while running
  - conditional/unconditional jumps, HALT, carry flag
  - pause/resume on `en`
- Sits as the top-level compute core; a testbench or loader drives the program port.

Parameters:
- DW, 16, data word width (A, B, C, data-memory word).
- AW, 12, address width; IM and DM depth = 2**AW each.
- IW (localparam), 4+AW, instruction width: [IW-1:AW] opcode, [AW-1:0] address/immediate field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- prog_we  in  1  instruction-memory write strobe.
- prog_addr  in  AW  IM write address.
- prog_data  in  IW  IM write data.
- busy  out  1  high in FETCH/DECODE/EXEC/MEM.
- halted  out  1  high in HALT state.
- pc  out  AW  current program counter.
- c_out  out  DW  register C.
- za, zb  out  1  A==0, B==0 (registered; update the cycle after A/B is written).
- eq, gt, lt  out  1  unsigned compare A vs B, updated by CMP only.
- cy  out  1  carry/borrow from last ADD/SUB/SHL.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; PC, IR, A, B, C = 0.
  - za=zb=1, eq=gt=lt=cy=0, busy=halted=0.
  - IM/DM contents are not cleared.
  - Reset in any state, including mid-instruction, aborts that instruction; no pending DM write completes.
- Memories: synchronous write, registered (1-cycle) read.
  - prog_we is honoured only in IDLE or HALT; ignored while busy.
- FSM:
  - IDLE -> FETCH when en=1.
  - FETCH: IM read at PC.
  - DECODE: IR <= IM data; PC <= PC+1, modulo 2**AW (wraps from all-ones to 0).
  - EXEC: execute; DM address = IR[AW-1:0].
  - LDA/LDB: EXEC -> MEM (4 cycles total). MEM: A or B <= DM data.
  - All other opcodes: 3 cycles total; EXEC (or MEM) -> FETCH if en=1, else -> IDLE (pause; PC is kept, resumes on en=1).
  - HLT: EXEC -> HALT. HALT holds until en=0, then -> IDLE with PC <= 0.
- Opcodes (imm = IR[AW-1:0]):
  - 0 NOP.
  - 1 LDA: A <= DM[imm].
  - 2 LDB: B <= DM[imm].
  - 3 STC: DM[imm] <= C.
  - 4 LDI: A <= zero-extend(imm), or truncate to DW if AW>DW.
  - 5 ADD: {cy,C} <= A+B.
  - 6 SUB: C <= A-B; cy = borrow (A<B).
  - 7 AND, 8 OR, 9 XOR: C <= A op B; cy unchanged.
  - 10 SHL: C <= A<<1; cy <= A[DW-1].
  - 11 CMP: eq/gt/lt <= unsigned A vs B; exactly one is set.
  - 12 JMP: PC <= imm.
  - 13 JZ: PC <= imm if za.
  - 14 JLT: PC <= imm if lt.
  - 15 HLT.
- Jumps overwrite the PC+1 written in DECODE.
- Flags sampled by JZ/JLT are the values registered before EXEC.
- Arithmetic is modulo 2**DW.

Decomposition:
- Shared package cpu_core_pkg holds:
  - opcode enum (4-bit, values above)
  - FSM state enum (IDLE, FETCH, DECODE, EXEC, MEM, HALT)
  - default DW/AW constants
- One sub-module, cpu_core_alu: combinational; inputs A, B, opcode; outputs result, carry, eq/gt/lt.
- Memories are inferred arrays inside cpu_core.

Test Plan:
- Reset/idle: rst pulse with en=0 -> busy=0, pc=0, za=zb=1, c_out=0. Assert en=1 -> busy=1 on the next cycle.
- Load/add/store: program LDA 5; LDB 6; ADD; STC 7; HLT with DM[5]=0xFFFF, DM[6]=0x0002 -> C=0x0001, cy=1, DM[7]=0x0001, halted=1 after 4+4+3+3+3=17 busy cycles.
- Compare/branch: LDI 3; LDB 9 (DM[9]=5); CMP; JLT 0x010; LDI 1; HLT at 0x010 -> lt=1, eq=gt=0, pc=0x011 in HALT, A=3 (LDI 1 skipped).
- PC wrap: JMP to 0xFFF holding NOP; 0x000 holds HLT -> after NOP, pc wraps to 0 and the core halts.
- Pause and lockout: drop en mid-ADD -> instruction completes, state IDLE, pc preserved. A prog_we pulse during busy leaves IM unchanged; re-raise en -> execution resumes correctly.
- Reset mid-instruction: rst during EXEC of STC -> target DM word unchanged, all outputs at reset values.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// Shared types and defaults for the accumulator CPU core: opcode and FSM
// state encodings plus the default data/address widths.
package cpu_core_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 12;
    localparam int OPC_W  = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_LDB = 4'd2,
        OP_STC = 4'd3,
        OP_LDI = 4'd4,
        OP_ADD = 4'd5,
        OP_SUB = 4'd6,
        OP_AND = 4'd7,
        OP_OR  = 4'd8,
        OP_XOR = 4'd9,
        OP_SHL = 4'd10,
        OP_CMP = 4'd11,
        OP_JMP = 4'd12,
        OP_JZ  = 4'd13,
        OP_JLT = 4'd14,
        OP_HLT = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU: arithmetic/logic result with carry/borrow, plus the
// unsigned A-vs-B comparison used by CMP. The top decides which outputs
// are actually committed for the opcode in flight.
module cpu_core_alu
    import cpu_core_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    opcode,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          eq,
    output logic          gt,
    output logic          lt
);

    opcode_t       op_s;
    logic [DW:0]   sum_s;
    logic [DW:0]   diff_s;

    assign op_s   = opcode_t'(opcode);
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Result and carry per opcode; the borrow of SUB is the wrapped MSB of diff
    always_comb begin
        result = {DW{1'b0}};
        carry  = 1'b0;
        case (op_s)
            OP_ADD: begin
                result = sum_s[DW-1:0];
                carry  = sum_s[DW];
            end
            OP_SUB: begin
                result = diff_s[DW-1:0];
                carry  = diff_s[DW];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DW-2:0], 1'b0};
                carry  = a[DW-1];
            end
            default: begin
                result = {DW{1'b0}};
                carry  = 1'b0;
            end
        endcase
    end

    // Unsigned comparison; exactly one of the three is ever set
    always_comb begin
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU: instruction/data memories, PC, IR, A/B/C
// registers and flags sequenced by a six-state FSM. Programs are loaded
// through the prog_* port only while the core is idle or halted.
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [AW+3:0] prog_data,
    output logic          busy,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] c_out,
    output logic          za,
    output logic          zb,
    output logic          eq,
    output logic          gt,
    output logic          lt,
    output logic          cy
);

    localparam int IW = AW + OPC_W;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        next_state_s;

    logic [AW-1:0] pc_r;
    logic [IW-1:0] ir_r;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic [DW-1:0] c_r;
    logic          za_r;
    logic          zb_r;
    logic          eq_r;
    logic          gt_r;
    logic          lt_r;
    logic          cy_r;
    logic          busy_r;
    logic          halted_r;

    logic [IW-1:0] im_mem_r [0:DEPTH-1];
    logic [DW-1:0] dm_mem_r [0:DEPTH-1];
    logic [IW-1:0] im_rdata_r;
    logic [DW-1:0] dm_rdata_r;

    opcode_t       op_s;
    logic [AW-1:0] imm_s;
    logic [DW-1:0] imm_ext_s;

    logic          im_we_s;
    logic          dm_we_s;
    logic          ir_load_s;
    logic          exec_s;
    logic          mem_s;
    logic          pc_clear_s;

    logic [DW-1:0] alu_result_s;
    logic          alu_carry_s;
    logic          alu_eq_s;
    logic          alu_gt_s;
    logic          alu_lt_s;

    assign op_s      = opcode_t'(ir_r[IW-1:AW]);
    assign imm_s     = ir_r[AW-1:0];
    assign imm_ext_s = DW'(imm_s);

    cpu_core_alu #(.DW(DW)) u_alu (
        .a      (a_r),
        .b      (b_r),
        .opcode (ir_r[IW-1:AW]),
        .result (alu_result_s),
        .carry  (alu_carry_s),
        .eq     (alu_eq_s),
        .gt     (alu_gt_s),
        .lt     (alu_lt_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; dropping en pauses only at an instruction boundary
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) next_state_s = ST_FETCH;
                else    next_state_s = ST_IDLE;
            end
            ST_FETCH:  next_state_s = ST_DECODE;
            ST_DECODE: next_state_s = ST_EXEC;
            ST_EXEC: begin
                case (op_s)
                    OP_LDA, OP_LDB: next_state_s = ST_MEM;
                    OP_HLT:         next_state_s = ST_HALT;
                    default: begin
                        if (en) next_state_s = ST_FETCH;
                        else    next_state_s = ST_IDLE;
                    end
                endcase
            end
            ST_MEM: begin
                if (en) next_state_s = ST_FETCH;
                else    next_state_s = ST_IDLE;
            end
            ST_HALT: begin
                if (en) next_state_s = ST_HALT;
                else    next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM control strobes decoded from the current state
    always_comb begin
        im_we_s    = 1'b0;
        dm_we_s    = 1'b0;
        ir_load_s  = 1'b0;
        exec_s     = 1'b0;
        mem_s      = 1'b0;
        pc_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                im_we_s = prog_we;
            end
            ST_DECODE: begin
                ir_load_s = 1'b1;
            end
            ST_EXEC: begin
                exec_s = 1'b1;
                if (op_s == OP_STC) dm_we_s = 1'b1;
                else                dm_we_s = 1'b0;
            end
            ST_MEM: begin
                mem_s = 1'b1;
            end
            ST_HALT: begin
                im_we_s = prog_we;
                if (!en) pc_clear_s = 1'b1;
                else     pc_clear_s = 1'b0;
            end
            default: begin
                im_we_s = 1'b0;
            end
        endcase
    end

    // Instruction memory write port; a reset cycle never commits a write
    always_ff @(posedge clk) begin
        if (im_we_s && !rst) begin
            im_mem_r[prog_addr] <= prog_data;
        end
    end

    // Data memory write port; reset during STC aborts the store
    always_ff @(posedge clk) begin
        if (dm_we_s && !rst) begin
            dm_mem_r[imm_s] <= c_r;
        end
    end

    // Registered memory reads: IM at PC, DM at the IR address field
    always_ff @(posedge clk) begin
        if (rst) begin
            im_rdata_r <= {IW{1'b0}};
            dm_rdata_r <= {DW{1'b0}};
        end else begin
            im_rdata_r <= im_mem_r[pc_r];
            dm_rdata_r <= dm_mem_r[imm_s];
        end
    end

    // Architectural registers, flags and PC sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= {AW{1'b0}};
            ir_r <= {IW{1'b0}};
            a_r  <= {DW{1'b0}};
            b_r  <= {DW{1'b0}};
            c_r  <= {DW{1'b0}};
            za_r <= 1'b1;
            zb_r <= 1'b1;
            eq_r <= 1'b0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
            cy_r <= 1'b0;
        end else begin
            // zero flags trail the register write by one cycle
            za_r <= (a_r == {DW{1'b0}});
            zb_r <= (b_r == {DW{1'b0}});
            if (ir_load_s) begin
                ir_r <= im_rdata_r;
                pc_r <= pc_r + PC_ONE;
            end
            if (pc_clear_s) begin
                pc_r <= {AW{1'b0}};
            end
            if (exec_s) begin
                case (op_s)
                    OP_LDI: a_r <= imm_ext_s;
                    OP_ADD, OP_SUB, OP_SHL: begin
                        c_r  <= alu_result_s;
                        cy_r <= alu_carry_s;
                    end
                    OP_AND, OP_OR, OP_XOR: c_r <= alu_result_s;
                    OP_CMP: begin
                        eq_r <= alu_eq_s;
                        gt_r <= alu_gt_s;
                        lt_r <= alu_lt_s;
                    end
                    OP_JMP: pc_r <= imm_s;
                    OP_JZ:  if (za_r) pc_r <= imm_s;
                    OP_JLT: if (lt_r) pc_r <= imm_s;
                    default: begin
                    end
                endcase
            end
            if (mem_s) begin
                case (op_s)
                    OP_LDA:  a_r <= dm_rdata_r;
                    OP_LDB:  b_r <= dm_rdata_r;
                    default: begin
                    end
                endcase
            end
        end
    end

    // Status outputs registered from the next state so they track the FSM exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            busy_r   <= (next_state_s == ST_FETCH) || (next_state_s == ST_DECODE) ||
                        (next_state_s == ST_EXEC)  || (next_state_s == ST_MEM);
            halted_r <= (next_state_s == ST_HALT);
        end
    end

    assign busy   = busy_r;
    assign halted = halted_r;
    assign pc     = pc_r;
    assign c_out  = c_r;
    assign za     = za_r;
    assign zb     = zb_r;
    assign eq     = eq_r;
    assign gt     = gt_r;
    assign lt     = lt_r;
    assign cy     = cy_r;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: small hand-assembled programs with
// hand-computed results for reset, load/add/store, compare/branch,
// PC wrap, pause, load lockout and reset mid-instruction.
module tb_cpu_core;
    import cpu_core_pkg::*;

    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic          en;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [AW+3:0] prog_data;
    logic          busy;
    logic          halted;
    logic [AW-1:0] pc;
    logic [DW-1:0] c_out;
    logic          za;
    logic          zb;
    logic          eq;
    logic          gt;
    logic          lt;
    logic          cy;

    int errors_cnt;
    int checks_cnt;
    int busy_cycles;

    cpu_core #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .c_out     (c_out),
        .za        (za),
        .zb        (zb),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .cy        (cy)
    );

    // free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one-cycle IM write, driven just after a falling edge
    task automatic prog(input logic [AW-1:0] addr, input opcode_t op, input logic [AW-1:0] imm);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = {op, imm};
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // run with en high until halted; counts busy cycles, bounded
    task automatic run_until_halt(input int max_cycles, output int n_busy);
        n_busy = 0;
        en = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (halted) break;
            if (busy) n_busy++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic leave_halt();
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        errors_cnt = 0;
        checks_cnt = 0;
        rst       = 1'b1;
        en        = 1'b0;
        prog_we   = 1'b0;
        prog_addr = {AW{1'b0}};
        prog_data = {(AW+4){1'b0}};
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // setup program: builds DM[9]=5, DM[6]=2, DM[1]=1, DM[5]=0xFFFF
        prog(12'd0,  OP_LDI, 12'd5);
        prog(12'd1,  OP_OR,  12'd0);
        prog(12'd2,  OP_STC, 12'd9);
        prog(12'd3,  OP_LDI, 12'd1);
        prog(12'd4,  OP_SHL, 12'd0);
        prog(12'd5,  OP_STC, 12'd6);
        prog(12'd6,  OP_OR,  12'd0);
        prog(12'd7,  OP_STC, 12'd1);
        prog(12'd8,  OP_LDB, 12'd1);
        prog(12'd9,  OP_LDI, 12'd0);
        prog(12'd10, OP_SUB, 12'd0);
        prog(12'd11, OP_STC, 12'd5);
        prog(12'd12, OP_HLT, 12'd0);

        // reset / idle state
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc",     {20'd0, pc},     32'd0);
        check("rst_za",     {31'd0, za},     32'd1);
        check("rst_zb",     {31'd0, zb},     32'd1);
        check("rst_c",      {16'd0, c_out},  32'd0);
        check("rst_cy",     {31'd0, cy},     32'd0);
        check("rst_cmp",    {29'd0, eq, gt, lt}, 32'd0);
        en = 1'b1;
        @(negedge clk);
        check("busy_on_en", {31'd0, busy}, 32'd1);
        run_until_halt(200, busy_cycles);
        check("setup_c",  {16'd0, c_out}, 32'h0000_FFFF);
        check("setup_cy", {31'd0, cy},    32'd1);
        check("setup_pc", {20'd0, pc},    32'd13);
        check("setup_za", {31'd0, za},    32'd1);
        check("setup_zb", {31'd0, zb},    32'd0);

        // load/add/store
        leave_halt();
        check("halt_exit_pc", {20'd0, pc}, 32'd0);
        do_reset();
        prog(12'd0, OP_LDA, 12'd5);
        prog(12'd1, OP_LDB, 12'd6);
        prog(12'd2, OP_ADD, 12'd0);
        prog(12'd3, OP_STC, 12'd7);
        prog(12'd4, OP_HLT, 12'd0);
        run_until_halt(100, busy_cycles);
        check("add_busy_cycles", busy_cycles,     32'd17);
        check("add_c",           {16'd0, c_out},  32'h0000_0001);
        check("add_cy",          {31'd0, cy},     32'd1);
        check("add_dm7",         {16'd0, dut.dm_mem_r[7]}, 32'h0000_0001);
        check("add_pc",          {20'd0, pc},     32'd5);
        check("add_za",          {31'd0, za},     32'd0);

        // compare / branch
        leave_halt();
        do_reset();
        prog(12'd0,    OP_LDI, 12'd3);
        prog(12'd1,    OP_LDB, 12'd9);
        prog(12'd2,    OP_CMP, 12'd0);
        prog(12'd3,    OP_JLT, 12'h010);
        prog(12'd4,    OP_LDI, 12'd1);
        prog(12'h010,  OP_HLT, 12'd0);
        run_until_halt(100, busy_cycles);
        check("cmp_flags", {29'd0, eq, gt, lt}, 32'd1);
        check("cmp_pc",    {20'd0, pc},         32'h011);
        check("cmp_a",     {16'd0, dut.a_r},    32'd3);

        // PC wrap with a pause right after JMP, plus load lockout while busy
        leave_halt();
        check("wrap_start_pc", {20'd0, pc}, 32'd0);
        prog(12'd0,     OP_JMP, 12'hFFF);
        prog(12'hFFF,   OP_NOP, 12'd0);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("jmp_pause_busy", {31'd0, busy}, 32'd0);
        check("jmp_pause_pc",   {20'd0, pc},   32'hFFF);
        prog(12'd0, OP_HLT, 12'd0);
        en = 1'b1;
        @(negedge clk);
        prog(12'd0, OP_LDI, 12'h055);
        run_until_halt(40, busy_cycles);
        check("wrap_pc", {20'd0, pc}, 32'd1);

        // pause during ADD, then resume
        leave_halt();
        do_reset();
        prog(12'd0, OP_LDI, 12'd7);
        prog(12'd1, OP_ADD, 12'd0);
        prog(12'd2, OP_HLT, 12'd0);
        en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("pause_in_flight", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("pause_busy", {31'd0, busy},  32'd0);
        check("pause_c",    {16'd0, c_out}, 32'd7);
        check("pause_pc",   {20'd0, pc},    32'd2);
        @(negedge clk);
        check("pause_hold", {31'd0, busy}, 32'd0);
        run_until_halt(40, busy_cycles);
        check("resume_pc", {20'd0, pc}, 32'd3);

        // reset in EXEC of STC
        leave_halt();
        do_reset();
        prog(12'd0, OP_LDI, 12'h0AB);
        prog(12'd1, OP_OR,  12'd0);
        prog(12'd2, OP_STC, 12'd6);
        prog(12'd3, OP_HLT, 12'd0);
        en = 1'b1;
        repeat (9) @(negedge clk);
        check("pre_rst_c", {16'd0, c_out}, 32'h0AB);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_dm6",   {16'd0, dut.dm_mem_r[6]}, 32'd2);
        check("abort_busy",  {31'd0, busy},   32'd0);
        check("abort_halt",  {31'd0, halted}, 32'd0);
        check("abort_pc",    {20'd0, pc},     32'd0);
        check("abort_c",     {16'd0, c_out},  32'd0);
        check("abort_flags", {26'd0, za, zb, eq, gt, lt, cy}, 32'b110000);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
